// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - per-neuron spike counting over a window followed by a sequential argmax
//
// Counts output spikes of the LSNN layer per neuron across window_len accepted
// timesteps, then scans the counters one neuron per cycle to find the most
// active neuron (ties go to the lowest index).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  design enable, qualifies spike_valid only
//   spikes_in           spike vector, bit i = neuron i fired this timestep
//   spike_valid         strobe marking a completed timestep on spikes_in
//   window_len          timesteps per window, latched on an accepted start
//   start               begin a new window (honoured only when idle)
//   busy                high while counting or scanning
//   done                one-cycle pulse when winner_idx/winner_cnt are valid
//   winner_idx          index of the neuron with the highest count
//   winner_cnt          count of that neuron
//   overflow            sticky: a counter saturated during the current window
//   rd_sel / rd_cnt     combinational readback of the live counter array

module spike_rate_decoder #(
  parameter int N_NEURONS = 8,
  parameter int CNT_W     = 8,
  parameter int WIN_W     = 8,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic                 spike_valid,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [CNT_W-1:0]     winner_cnt,
  output logic                 overflow,
  input  logic [IDX_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]     rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_NEURONS];
  logic [CNT_W-1:0] cnt_d [N_NEURONS];
  logic [WIN_W-1:0] step_q, step_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] winner_idx_q, winner_idx_d;
  logic [CNT_W-1:0] winner_cnt_q, winner_cnt_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic [CNT_W-1:0] cand;

  assign accept = spike_valid & en;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    win_d        = win_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    winner_idx_d = winner_idx_q;
    winner_cnt_d = winner_cnt_q;
    overflow_d   = overflow_q;
    cand         = cnt_q[scan_idx_q];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N_NEURONS; i++) cnt_d[i] = '0;
          overflow_d   = 1'b0;
          winner_idx_d = '0;
          winner_cnt_d = '0;
          step_d       = '0;
          win_d        = window_len;
          scan_idx_d   = '0;
          // An empty window has nothing to count; go straight to the scan,
          // which then reports neuron 0 with a count of 0.
          state_d      = (window_len == '0) ? S_SCAN : S_COUNT;
        end
      end

      S_COUNT: begin
        if (accept) begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (spikes_in[i]) begin
              if (cnt_q[i] == CNT_MAX) overflow_d = 1'b1;
              else                     cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
          step_d = step_q + WIN_ONE;
          if (step_d == win_q) begin
            scan_idx_d = '0;
            state_d    = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        // Neuron 0 seeds the running best; later neurons must strictly
        // exceed it, which makes ties resolve to the lowest index.
        if (scan_idx_q == '0 || cand > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = cand;
        end
        scan_idx_d = scan_idx_q + IDX_ONE;
        if (scan_idx_q == IDX_LAST) begin
          winner_idx_d = best_idx_d;
          winner_cnt_d = best_cnt_d;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
      step_q       <= '0;
      win_q        <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      winner_idx_q <= '0;
      winner_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= cnt_d[i];
      step_q       <= step_d;
      win_q        <= win_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      winner_idx_q <= winner_idx_d;
      winner_cnt_q <= winner_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q == S_COUNT) || (state_q == S_SCAN);
  assign done       = (state_q == S_DONE);
  assign winner_idx = winner_idx_q;
  assign winner_cnt = winner_cnt_q;
  assign overflow   = overflow_q;
  assign rd_cnt     = cnt_q[rd_sel];

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - randomized self-checking bench for spike_rate_decoder
//
// Two instances (8-bit and 4-bit counters) share all inputs; a behavioural
// model keeps unsaturated spike totals and derives both instances' outputs.

module tb_spike_rate_decoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, en, spike_valid, start;
  logic [7:0] spikes_in, window_len;
  logic [2:0] rd_sel;

  logic       busy8, done8, ovf8;
  logic [2:0] widx8;
  logic [7:0] wcnt8, rd8;
  logic       busy4, done4, ovf4;
  logic [2:0] widx4;
  logic [3:0] wcnt4, rd4;

  spike_rate_decoder #(.N_NEURONS(8), .CNT_W(8), .WIN_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .spikes_in(spikes_in), .spike_valid(spike_valid),
    .window_len(window_len), .start(start), .busy(busy8), .done(done8),
    .winner_idx(widx8), .winner_cnt(wcnt8), .overflow(ovf8), .rd_sel(rd_sel), .rd_cnt(rd8)
  );

  spike_rate_decoder #(.N_NEURONS(8), .CNT_W(4), .WIN_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .spikes_in(spikes_in), .spike_valid(spike_valid),
    .window_len(window_len), .start(start), .busy(busy4), .done(done4),
    .winner_idx(widx4), .winner_cnt(wcnt4), .overflow(ovf4), .rd_sel(rd_sel), .rd_cnt(rd4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 collecting timesteps, 2 scanning, 3 results pulse
  int total [N];
  int m_mode = 0;
  int m_win, m_steps, m_scan_left;
  int m_widx8, m_wcnt8, m_widx4, m_wcnt4;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int best_of(int mx);
    int b = 0;
    for (int i = 1; i < N; i++)
      if (sat(total[i], mx) > sat(total[b], mx)) b = i;
    return b;
  endfunction

  function automatic bit any_over(int mx);
    for (int i = 0; i < N; i++) if (total[i] > mx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) total[i] = 0;
    m_steps = 0;
    m_widx8 = 0; m_wcnt8 = 0; m_widx4 = 0; m_wcnt4 = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
      m_win  = 0;
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          model_clear();
          m_win = window_len;
          if (m_win == 0) begin m_mode = 2; m_scan_left = N; end
          else m_mode = 1;
        end
        1: if (spike_valid && en) begin
          for (int i = 0; i < N; i++) total[i] += spikes_in[i];
          m_steps++;
          if (m_steps == m_win) begin m_mode = 2; m_scan_left = N; end
        end
        2: begin
          m_scan_left--;
          if (m_scan_left == 0) begin
            m_mode  = 3;
            m_widx8 = best_of(255); m_wcnt8 = sat(total[m_widx8], 255);
            m_widx4 = best_of(15);  m_wcnt4 = sat(total[m_widx4], 15);
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking_on) begin
      chk("busy8", busy8, (m_mode == 1 || m_mode == 2));
      chk("done8", done8, (m_mode == 3));
      chk("widx8", widx8, m_widx8);
      chk("wcnt8", wcnt8, m_wcnt8);
      chk("ovf8",  ovf8,  any_over(255));
      chk("rd8",   rd8,   sat(total[rd_sel], 255));
      chk("busy4", busy4, (m_mode == 1 || m_mode == 2));
      chk("done4", done4, (m_mode == 3));
      chk("widx4", widx4, m_widx4);
      chk("wcnt4", wcnt4, m_wcnt4);
      chk("ovf4",  ovf4,  any_over(15));
      chk("rd4",   rd4,   sat(total[rd_sel], 15));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit st, input logic [7:0] wl, input bit sv, input bit e,
                      input logic [7:0] sp);
    start = st; window_len = wl; spike_valid = sv; en = e; spikes_in = sp;
    rd_sel = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 1'b0, 1'($urandom), 8'($urandom));
  endtask

  // Random start/window/spike activity that the design must ignore here.
  task automatic noise();
    step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 1;
    while (!done8 && lat < 40) begin
      noise();
      lat++;
    end
    chk({name, "_done_seen"}, done8, 1);
  endtask

  task automatic sweep_literal(input string name, input int exp [N]);
    for (int i = 0; i < N; i++) begin
      rd_sel = 3'(i);
      #1;
      chk(name, rd8, exp[i]);
    end
  endtask

  int lat;
  int exp_basic [N] = '{1, 0, 4, 0, 0, 0, 0, 1};
  int exp_zero  [N] = '{0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1; en = 1'b0; spike_valid = 1'b0; start = 1'b0;
    spikes_in = '0; window_len = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checking_on = 1'b1;
    chk("reset_busy", busy8, 0);
    chk("reset_widx", widx8, 0);

    // Basic window
    idle();
    step(1'b1, 8'd4, 1'b0, 1'b1, 8'h00);
    step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'h05);
    step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'h04);
    step(1'b1, 8'd1, 1'b1, 1'b1, 8'h84);
    step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'h04);
    wait_done("basic", lat);
    chk("basic_latency", lat, 9);
    chk("basic_widx", widx8, 2);
    chk("basic_wcnt", wcnt8, 4);
    step(1'b1, 8'd3, 1'b0, 1'b1, 8'h00);   // start during results pulse is ignored
    sweep_literal("basic_held_rd", exp_basic);
    chk("basic_held_widx", widx8, 2);

    // Tie with a gated timestep in between
    step(1'b1, 8'd2, 1'b0, 1'b1, 8'h00);
    step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'h22);
    step(1'b0, 8'($urandom), 1'b1, 1'b0, 8'hFF);
    step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'h22);
    wait_done("tie", lat);
    chk("tie_latency", lat, 9);
    chk("tie_widx", widx8, 1);
    chk("tie_wcnt", wcnt8, 2);
    idle();

    // Saturation: 255-step window then a 20-step window back to back
    step(1'b1, 8'd255, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 255; i++) step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'hFF);
    wait_done("sat255", lat);
    chk("sat255_wcnt8", wcnt8, 255);
    chk("sat255_ovf8", ovf8, 0);
    chk("sat255_wcnt4", wcnt4, 15);
    chk("sat255_ovf4", ovf4, 1);
    idle();
    step(1'b1, 8'd20, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'hFF);
    wait_done("sat20", lat);
    chk("sat20_wcnt8", wcnt8, 20);
    chk("sat20_wcnt4", wcnt4, 15);
    chk("sat20_ovf4", ovf4, 1);
    chk("sat20_widx4", widx4, 0);
    idle();

    // Zero-length window, with start pulses thrown at it while busy
    step(1'b1, 8'd0, 1'b1, 1'b1, 8'hFF);
    wait_done("zero", lat);
    chk("zero_latency", lat, 9);
    chk("zero_widx", widx8, 0);
    chk("zero_wcnt", wcnt8, 0);
    idle();

    // Reset in the middle of a window
    step(1'b1, 8'd10, 1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 8'($urandom), 1'b1, 1'b1, 8'($urandom));
    rst = 1'b1;
    noise();
    noise();
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_widx", widx8, 0);
    chk("rst_ovf", ovf8, 0);
    sweep_literal("rst_rd", exp_zero);
    repeat (15) idle();

    // Randomized windows
    for (int w = 0; w < 30; w++) begin
      int budget;
      idle();
      step(1'b1, 8'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 8'($urandom));
      budget = 0;
      while (m_mode == 1 && budget < 200) begin
        step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        budget++;
      end
      chk("rand_window_ended", (m_mode != 1), 1);
      wait_done("rand", lat);
      repeat ($urandom_range(0, 3)) idle();
    end

    checking_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
